board_color_mapper: RTL and testbench

Pipelined, parametrised colour mapper for the Tetris playfield. It tracks the VGA scan position with incremental cell counters, so no divider is needed. It fetches each cell's code from the board RAM and overlays the falling piece. It applies flash and border styling and outputs registered RGB with sync/blank delayed to match. It sits between the VGA controller and the DAC.

---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/scan_cell_tracker.sv | 74 +++++++
 rtl/board_color_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_board_color_mapper.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and colour constants for the Tetris playfield video path.
package tetris_pkg;

    localparam int COORD_W = 10;
    localparam int CELL_W  = 3;

    typedef logic [CELL_W-1:0] cell_code_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
    } vga_ctrl_t;

    // Blank asserted (low) and both syncs idle (high) while in reset.
    localparam vga_ctrl_t CTRL_RESET = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

    localparam rgb_t BLACK_RGB  = 24'h000000;
    localparam rgb_t BORDER_RGB = 24'hFF5500;
    localparam rgb_t FLASH_RGB  = 24'hFFFFFF;
    localparam rgb_t GRID_RGB   = 24'h404040;

    localparam rgb_t PALETTE [8] = '{
        24'h000000, 24'h00FFFF, 24'hFFFF00, 24'h800080,
        24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF7F00
    };

    function automatic rgb_t palette_rgb(input cell_code_t code);
        return PALETTE[code];
    endfunction

    // Blue ramp across the screen, darkening to the right in 8-pixel steps.
    function automatic rgb_t background_rgb(input logic [6:0] xcol);
        rgb_t c;
        c.r = 8'h00;
        c.g = 8'h00;
        c.b = 8'h7F - {1'b0, xcol};
        return c;
    endfunction

endpackage

// File: rtl/scan_cell_tracker.sv
// One scan axis: cell index, sub-pixel counter and in-range flag, advanced
// incrementally. Optional BOARD_GRID_LINES_EN adds the cell-edge output.
module scan_cell_tracker
    import tetris_pkg::*;
#(
    parameter int COUNT  = 12,
    parameter int SQUARE = 26,
    parameter int ORIGIN = 160,
    localparam int POS_W = $clog2(COUNT),
    localparam int SUB_W = $clog2(SQUARE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_i,
    input  logic [COORD_W-1:0] coord_i,
    output logic [POS_W-1:0]   pos_o,
    output logic               in_range_o
`ifdef BOARD_GRID_LINES_EN
    ,
    output logic               on_line_o
`endif
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             in_q, in_d;

    // The _d values describe the coordinate presented this cycle; _q holds the previous one.
    always_comb begin
        // NOTE: every variable gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
        pos_d = pos_q;
        sub_d = sub_q;
        in_d  = in_q;
        if (step_i) begin
            if (coord_i == COORD_W'(ORIGIN)) begin
                pos_d = '0;
                sub_d = '0;
                in_d  = 1'b1;
            end else if (in_q) begin
                if (sub_q == SUB_W'(SQUARE - 1)) begin
                    sub_d = '0;
                    if (pos_q == POS_W'(COUNT - 1)) begin
                        pos_d = '0;
                        in_d  = 1'b0;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            pos_q <= '0;
            sub_q <= '0;
            in_q  <= 1'b0;
        end else begin
            pos_q <= pos_d;
            sub_q <= sub_d;
            in_q  <= in_d;
        end
    end

    assign pos_o      = pos_d;
    assign in_range_o = in_d;
`ifdef BOARD_GRID_LINES_EN
    assign on_line_o  = (sub_d == '0);
`endif

endmodule

// File: rtl/board_color_mapper.sv
// Three-stage VGA colour mapper for the Tetris board: address, colour select, output.
// Define BOARD_GRID_LINES_EN to draw dark-grey cell edges over empty cells.
module board_color_mapper
    import tetris_pkg::*;
#(
    parameter int BOARD_COLS  = 12,
    parameter int BOARD_ROWS  = 18,
    parameter int SQUARE      = 26,
    parameter int BOARD_X0    = 160,
    parameter int BOARD_Y0    = 0,
    parameter int BORDER_W    = 13,
    parameter int CELL_W      = tetris_pkg::CELL_W,
    parameter int FLASH_SHIFT = 3,
    localparam int ADDR_W     = $clog2(BOARD_COLS * BOARD_ROWS)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic                  blank_in,
    input  logic                  hs_in,
    input  logic                  vs_in,
    output logic [ADDR_W-1:0]     cell_addr,
    input  logic [CELL_W-1:0]     cell_data,
    input  logic [3:0]            piece_col,
    input  logic [4:0]            piece_row,
    input  logic [15:0]           piece_mask,
    input  logic [CELL_W-1:0]     piece_code,
    input  logic [BOARD_ROWS-1:0] flash_row_mask,
    output logic [7:0]            Red,
    output logic [7:0]            Green,
    output logic [7:0]            Blue,
    output logic                  blank_out,
    output logic                  hs_out,
    output logic                  vs_out
);

    localparam int COL_W = $clog2(BOARD_COLS);
    localparam int ROW_W = $clog2(BOARD_ROWS);
    localparam logic [COORD_W-1:0] BORDER_L_LO = COORD_W'(BOARD_X0 - BORDER_W);
    localparam logic [COORD_W-1:0] BORDER_L_HI = COORD_W'(BOARD_X0);
    localparam logic [COORD_W-1:0] BORDER_R_LO = COORD_W'(BOARD_X0 + BOARD_COLS * SQUARE);
    localparam logic [COORD_W-1:0] BORDER_R_HI = COORD_W'(BOARD_X0 + BOARD_COLS * SQUARE + BORDER_W);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             in_x, in_y;
`ifdef BOARD_GRID_LINES_EN
    logic             line_x, line_y;
`endif

    scan_cell_tracker #(
        .COUNT  (BOARD_COLS),
        .SQUARE (SQUARE),
        .ORIGIN (BOARD_X0)
    ) u_x_tracker (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .step_i     (1'b1),
        .coord_i    (DrawX),
        .pos_o      (col),
        .in_range_o (in_x)
`ifdef BOARD_GRID_LINES_EN
        ,
        .on_line_o  (line_x)
`endif
    );

    // Rows advance once per line, on the first pixel of the line.
    scan_cell_tracker #(
        .COUNT  (BOARD_ROWS),
        .SQUARE (SQUARE),
        .ORIGIN (BOARD_Y0)
    ) u_y_tracker (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .step_i     (DrawX == '0),
        .coord_i    (DrawY),
        .pos_o      (row),
        .in_range_o (in_y)
`ifdef BOARD_GRID_LINES_EN
        ,
        .on_line_o  (line_y)
`endif
    );

    // ---------------- stage 1: address and pixel classification
    logic [ADDR_W-1:0] cell_addr_q, cell_addr_d;
    logic              in_board_q, in_board_d;
    logic              border_q, border_d;
    logic              hit_q, hit_d;
    logic              flash_q;
    logic [6:0]        xcol_q;
    cell_code_t        pcode_q;
    vga_ctrl_t         ctrl_s1_q, ctrl_s2_q, ctrl_s3_q;
    logic [7:0]        dcol, drow;
`ifdef BOARD_GRID_LINES_EN
    logic              grid_q;
`endif

    always_comb begin
        cell_addr_d = ADDR_W'(row) * ADDR_W'(BOARD_COLS) + ADDR_W'(col);
        in_board_d  = in_x & in_y;
        border_d    = (DrawX >= BORDER_L_LO && DrawX < BORDER_L_HI) ||
                      (DrawX >= BORDER_R_LO && DrawX < BORDER_R_HI);
        // Unsigned offsets: a cell left of or above the piece box wraps high and misses.
        dcol  = 8'(col) - 8'(piece_col);
        drow  = 8'(row) - 8'(piece_row);
        hit_d = in_board_d && (dcol < 8'd4) && (drow < 8'd4) &&
                piece_mask[{drow[1:0], dcol[1:0]}];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cell_addr_q <= '0;
            in_board_q  <= 1'b0;
            border_q    <= 1'b0;
            hit_q       <= 1'b0;
            flash_q     <= 1'b0;
            xcol_q      <= '0;
            pcode_q     <= '0;
            ctrl_s1_q   <= CTRL_RESET;
`ifdef BOARD_GRID_LINES_EN
            grid_q      <= 1'b0;
`endif
        end else begin
            cell_addr_q <= cell_addr_d;
            in_board_q  <= in_board_d;
            border_q    <= border_d;
            hit_q       <= hit_d;
            flash_q     <= flash_row_mask[row];
            xcol_q      <= DrawX[9:3];
            pcode_q     <= cell_code_t'(piece_code);
            ctrl_s1_q   <= '{blank: blank_in, hs: hs_in, vs: vs_in};
`ifdef BOARD_GRID_LINES_EN
            grid_q      <= line_x | line_y;
`endif
        end
    end

    assign cell_addr = cell_addr_q;

    // ---------------- frame counter: counts vsync falling edges
    logic       vs_prev_q;
    logic [7:0] frame_cnt_q;
    logic       phase;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            vs_prev_q <= vs_in;
            if (vs_prev_q && !vs_in) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign phase = frame_cnt_q[FLASH_SHIFT];

    // ---------------- stage 2: colour select (cell_data answers cell_addr_q)
    rgb_t colour_q, colour_d;

    always_comb begin
        colour_d = background_rgb(xcol_q);
        if (hit_q && pcode_q != '0) begin
            colour_d = palette_rgb(pcode_q);
        end else if (in_board_q && flash_q && phase) begin
            colour_d = FLASH_RGB;
        end else if (in_board_q) begin
            colour_d = palette_rgb(cell_code_t'(cell_data));
        end else if (border_q) begin
            colour_d = BORDER_RGB;
        end
`ifdef BOARD_GRID_LINES_EN
        if (in_board_q && grid_q && colour_d == BLACK_RGB) begin
            colour_d = GRID_RGB;
        end
`endif
    end

    // ---------------- stages 2 and 3: colour register, blanked output register
    rgb_t out_rgb_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            colour_q  <= BLACK_RGB;
            ctrl_s2_q <= CTRL_RESET;
            out_rgb_q <= BLACK_RGB;
            ctrl_s3_q <= CTRL_RESET;
        end else begin
            colour_q  <= colour_d;
            ctrl_s2_q <= ctrl_s1_q;
            out_rgb_q <= ctrl_s2_q.blank ? colour_q : BLACK_RGB;
            ctrl_s3_q <= ctrl_s2_q;
        end
    end

    assign Red       = out_rgb_q.r;
    assign Green     = out_rgb_q.g;
    assign Blue      = out_rgb_q.b;
    assign blank_out = ctrl_s3_q.blank;
    assign hs_out    = ctrl_s3_q.hs;
    assign vs_out    = ctrl_s3_q.vs;

endmodule

// File: tb/tb_board_color_mapper.sv
// Directed bench for board_color_mapper: vector table plus reset, sync and flash sequences.
module tb_board_color_mapper;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank_in, hs_in, vs_in;
    logic [7:0]  cell_addr;
    logic [2:0]  cell_data;
    logic [3:0]  piece_col;
    logic [4:0]  piece_row;
    logic [15:0] piece_mask;
    logic [2:0]  piece_code;
    logic [17:0] flash_row_mask;
    logic [7:0]  Red, Green, Blue;
    logic        blank_out, hs_out, vs_out;

    int tests  = 0;
    int failed = 0;

    logic [2:0] board_mem [256];
    assign cell_data = board_mem[cell_addr];

    board_color_mapper dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .blank_in       (blank_in),
        .hs_in          (hs_in),
        .vs_in          (vs_in),
        .cell_addr      (cell_addr),
        .cell_data      (cell_data),
        .piece_col      (piece_col),
        .piece_row      (piece_row),
        .piece_mask     (piece_mask),
        .piece_code     (piece_code),
        .flash_row_mask (flash_row_mask),
        .Red            (Red),
        .Green          (Green),
        .Blue           (Blue),
        .blank_out      (blank_out),
        .hs_out         (hs_out),
        .vs_out         (vs_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          x;
        int          y;
        logic        blank;
        logic [3:0]  pcol;
        logic [4:0]  prow;
        logic [15:0] pmask;
        logic [2:0]  pcode;
        logic        chk_addr;
        logic [7:0]  addr;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int x, int y, logic b, logic [3:0] pc, logic [4:0] pr,
                                logic [15:0] pm, logic [2:0] pcd, logic ca,
                                logic [7:0] a, logic [23:0] c);
        vec_t v;
        v.x = x; v.y = y; v.blank = b;
        v.pcol = pc; v.prow = pr; v.pmask = pm; v.pcode = pcd;
        v.chk_addr = ca; v.addr = a; v.rgb = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic b);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        blank_in = b;
    endtask

    task automatic set_piece(input logic [3:0] pc, input logic [4:0] pr,
                             input logic [15:0] pm, input logic [2:0] pcd);
        piece_col  = pc;
        piece_row  = pr;
        piece_mask = pm;
        piece_code = pcd;
    endtask

    // Line starts from DrawY=0 down to y, then a pixel run along line y well past the board.
    task automatic scan_pixel(input int x, input int y, input logic b,
                              output logic [23:0] rgb, output logic [7:0] addr);
        rgb  = 'x;
        addr = 'x;
        for (int ly = 0; ly < y; ly++) begin
            drive(0, ly, b);
            tick();
        end
        for (int px = 0; px <= 520; px++) begin
            drive(px, y, b);
            tick();
            if (px == x)     addr = cell_addr;
            if (px == x + 2) rgb  = {Red, Green, Blue};
        end
    endtask

    task automatic vs_falls(input int n);
        drive(700, 500, 1'b0);
        for (int i = 0; i < n; i++) begin
            vs_in = 1'b0;
            tick();
            vs_in = 1'b1;
            tick();
        end
    endtask

    logic [23:0] got_rgb;
    logic [7:0]  got_addr;
    logic [23:0] grid_exp;

    initial begin
        for (int i = 0; i < 256; i++) board_mem[i] = 3'(i);

        Reset_n        = 1'b0;
        hs_in          = 1'b1;
        vs_in          = 1'b1;
        flash_row_mask = '0;
        set_piece(4'd0, 5'd0, 16'h0000, 3'd0);
        drive(0, 0, 1'b0);
        repeat (3) tick();
        Reset_n = 1'b1;

        // ---- reset in the middle of a frame
        for (int ly = 0; ly < 60; ly++) begin
            drive(0, ly, 1'b1);
            tick();
        end
        for (int px = 0; px <= 300; px++) begin
            drive(px, 60, 1'b1);
            tick();
        end
        Reset_n = 1'b0;
        #1;
        check("rst_rgb",       {Red, Green, Blue}, 24'h000000);
        check("rst_blank_out", blank_out, 1'b0);
        check("rst_hs_out",    hs_out, 1'b1);
        check("rst_vs_out",    vs_out, 1'b1);
        check("rst_cell_addr", cell_addr, 8'd0);
        tick();
        tick();
        drive(0, 0, 1'b1);
        Reset_n = 1'b1;
        tick();
        check("rel_e1_blank", blank_out, 1'b0);
        check("rel_e1_rgb",   {Red, Green, Blue}, 24'h000000);
        drive(1, 0, 1'b1);
        tick();
        check("rel_e2_blank", blank_out, 1'b0);
        check("rel_e2_rgb",   {Red, Green, Blue}, 24'h000000);
        drive(2, 0, 1'b1);
        tick();
        check("rel_e3_blank", blank_out, 1'b1);
        check("rel_e3_rgb",   {Red, Green, Blue}, 24'h00007F);
        for (int px = 3; px <= 160; px++) begin
            drive(px, 0, 1'b1);
            tick();
        end
        check("rel_first_board_addr", cell_addr, 8'd0);

        // ---- vector table
`ifdef BOARD_GRID_LINES_EN
        grid_exp = 24'h404040;
`else
        grid_exp = 24'h000000;
`endif
        vecs.push_back(mk(161,   1, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b1, 8'd0,   24'h000000));
        vecs.push_back(mk(243,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b1, 8'd27,  24'h800080));
        vecs.push_back(mk(243,  53, 1'b1, 4'd2, 5'd1, 16'h0020, 3'd1, 1'b1, 8'd27,  24'h00FFFF));
        vecs.push_back(mk(243,  53, 1'b1, 4'd2, 5'd1, 16'h0020, 3'd0, 1'b1, 8'd27,  24'h800080));
        vecs.push_back(mk(243,  53, 1'b1, 4'd4, 5'd1, 16'hFFFF, 3'd5, 1'b1, 8'd27,  24'h800080));
        vecs.push_back(mk(243,  53, 1'b1, 4'd0, 5'd0, 16'h0800, 3'd6, 1'b1, 8'd27,  24'h0000FF));
        vecs.push_back(mk(243,  53, 1'b1, 4'd0, 5'd0, 16'hF7FF, 3'd6, 1'b1, 8'd27,  24'h800080));
        vecs.push_back(mk(471,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b1, 8'd35,  24'h800080));
        vecs.push_back(mk(472,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'hFF5500));
        vecs.push_back(mk(150,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'hFF5500));
        vecs.push_back(mk(475,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'hFF5500));
        vecs.push_back(mk(484,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'hFF5500));
        vecs.push_back(mk(485,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'h000043));
        vecs.push_back(mk(146,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'h00006D));
        vecs.push_back(mk( 40,  53, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'h00007A));
        vecs.push_back(mk( 40,  53, 1'b0, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'h000000));
        vecs.push_back(mk(161, 467, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b1, 8'd204, 24'h00FF00));
        vecs.push_back(mk(161, 468, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b0, 8'd0,   24'h00006B));
        vecs.push_back(mk(186,   1, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b1, 8'd1,   24'h00FFFF));
        vecs.push_back(mk(160,  10, 1'b1, 4'd0, 5'd0, 16'h0000, 3'd0, 1'b1, 8'd0,   grid_exp));

        foreach (vecs[i]) begin
            set_piece(vecs[i].pcol, vecs[i].prow, vecs[i].pmask, vecs[i].pcode);
            scan_pixel(vecs[i].x, vecs[i].y, vecs[i].blank, got_rgb, got_addr);
            check($sformatf("vec%0d_rgb(x=%0d,y=%0d)", i, vecs[i].x, vecs[i].y), got_rgb, vecs[i].rgb);
            if (vecs[i].chk_addr)
                check($sformatf("vec%0d_addr", i), got_addr, vecs[i].addr);
        end
        set_piece(4'd0, 5'd0, 16'h0000, 3'd0);

        // ---- hsync travels through the same 3-stage delay
        drive(700, 100, 1'b0);
        hs_in = 1'b0;
        tick();
        hs_in = 1'b1;
        check("hs_delay_e1", hs_out, 1'b1);
        tick();
        check("hs_delay_e2", hs_out, 1'b1);
        tick();
        check("hs_delay_e3", hs_out, 1'b0);
        tick();
        check("hs_delay_e4", hs_out, 1'b1);

        // ---- row flash follows frame counter bit 3
        flash_row_mask = 18'h00004;
        scan_pixel(243, 53, 1'b1, got_rgb, got_addr);
        check("flash_frame0", got_rgb, 24'h800080);
        vs_falls(7);
        scan_pixel(243, 53, 1'b1, got_rgb, got_addr);
        check("flash_frame7", got_rgb, 24'h800080);
        vs_falls(1);
        scan_pixel(243, 53, 1'b1, got_rgb, got_addr);
        check("flash_frame8", got_rgb, 24'hFFFFFF);
        scan_pixel(186, 1, 1'b1, got_rgb, got_addr);
        check("flash_other_row", got_rgb, 24'h00FFFF);
        set_piece(4'd2, 5'd1, 16'h0020, 3'd1);
        scan_pixel(243, 53, 1'b1, got_rgb, got_addr);
        check("flash_piece_priority", got_rgb, 24'h00FFFF);
        set_piece(4'd0, 5'd0, 16'h0000, 3'd0);
        vs_falls(7);
        scan_pixel(243, 53, 1'b1, got_rgb, got_addr);
        check("flash_frame15", got_rgb, 24'hFFFFFF);
        vs_falls(1);
        scan_pixel(243, 53, 1'b1, got_rgb, got_addr);
        check("flash_frame16", got_rgb, 24'h800080);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
